// File: rtl/scan_mem_reg_bridge.sv
// rtl/scan_mem_reg_bridge.sv - scan port bridge to lane-packed SRAM and control/status registers
// Optional SRAM wait timeout is compiled in when SCAN_TIMEOUT_EN is defined.
module scan_mem_reg_bridge #(
    parameter int SCAN_W   = 32,
    parameter int SRAM_W   = 128,
    parameter int ADDR_W   = 11,
    parameter int NUM_REGS = 4,
    parameter int TIMEOUT  = 15,
    localparam int LANES   = SRAM_W / SCAN_W,
    localparam int LB      = $clog2(LANES),
    localparam int SA_W    = ADDR_W - 1 - LB,
    localparam int RI_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       scan_ren,
    input  logic                       scan_wen,
    input  logic [ADDR_W-1:0]          scan_addr,
    input  logic [SCAN_W-1:0]          scan_wdata,
    output logic [SCAN_W-1:0]          scan_rdata,
    output logic                       scan_ready,
    output logic                       scan_err,
    output logic                       scan_busy,
    output logic                       sram_ren,
    output logic                       sram_wen,
    output logic [SA_W-1:0]            sram_addr,
    output logic [SRAM_W-1:0]          sram_wdata,
    output logic [SRAM_W-1:0]          sram_bweb,
    input  logic [SRAM_W-1:0]          sram_rdata,
    input  logic                       sram_ready,
    output logic [NUM_REGS*SCAN_W-1:0] reg_q,
    input  logic [SCAN_W-1:0]          status_in
);

    localparam int LANE_W = (LB > 0) ? LB : 1;

    typedef enum logic [1:0] {IDLE, SRAM_REQ, SRAM_WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic              accept, illegal, is_reg, tmo_hit;
    logic [RI_W-1:0]   reg_idx;
    logic [ADDR_W-2:0] mem_off;
    logic [SA_W-1:0]   req_word;
    logic [LANE_W-1:0] req_lane;

    logic              cap_wen;
    logic [LANE_W-1:0] cap_lane;
    logic [SA_W-1:0]   cap_word;
    logic [SCAN_W-1:0] cap_wdata;

    assign accept   = (state == IDLE) && (scan_ren || scan_wen);
    assign illegal  = scan_ren && scan_wen;
    assign is_reg   = scan_addr[ADDR_W-1];
    assign reg_idx  = scan_addr[RI_W-1:0];
    assign mem_off  = scan_addr[ADDR_W-2:0];
    assign req_word = SA_W'(mem_off >> LB);
    assign req_lane = LANE_W'(mem_off & (ADDR_W-1)'(LANES - 1));

    assign scan_ready = (state == RESP);
    assign scan_busy  = (state != IDLE);
    assign sram_ren   = (state == SRAM_REQ) && !cap_wen;
    assign sram_wen   = (state == SRAM_REQ) && cap_wen;
    assign sram_addr  = cap_word;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (illegal || is_reg) ? RESP : SRAM_REQ;
            end
            SRAM_REQ:  state_nxt = SRAM_WAIT;
            SRAM_WAIT: begin
                if (sram_ready || tmo_hit) state_nxt = RESP;
            end
            RESP:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Write data lands only in its lane; other lanes are masked off by bweb.
    always_comb begin
        sram_wdata = '0;
        sram_bweb  = '1;
        if (sram_wen) begin
            sram_wdata[cap_lane*SCAN_W +: SCAN_W] = cap_wdata;
            sram_bweb[cap_lane*SCAN_W +: SCAN_W]  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_wen    <= 1'b0;
            cap_lane   <= '0;
            cap_word   <= '0;
            cap_wdata  <= '0;
            reg_q      <= '0;
            scan_rdata <= '0;
            scan_err   <= 1'b0;
        end else begin
            if (accept) begin
                cap_wen   <= scan_wen;
                cap_lane  <= req_lane;
                cap_word  <= req_word;
                cap_wdata <= scan_wdata;
                // Register-space responses are resolved on the accept edge.
                if (illegal) begin
                    scan_rdata <= '0;
                    scan_err   <= 1'b1;
                end else if (is_reg) begin
                    scan_rdata <= '0;
                    scan_err   <= 1'b1;
                    if (scan_wen) begin
                        if (reg_idx < RI_W'(NUM_REGS)) begin
                            reg_q[reg_idx*SCAN_W +: SCAN_W] <= scan_wdata;
                            scan_err <= 1'b0;
                        end
                    end else if (reg_idx < RI_W'(NUM_REGS)) begin
                        scan_rdata <= reg_q[reg_idx*SCAN_W +: SCAN_W];
                        scan_err   <= 1'b0;
                    end else if (reg_idx == RI_W'(NUM_REGS)) begin
                        scan_rdata <= status_in;
                        scan_err   <= 1'b0;
                    end
                end
            end
            if (state == SRAM_WAIT) begin
                if (sram_ready) begin
                    scan_rdata <= cap_wen ? '0 : sram_rdata[cap_lane*SCAN_W +: SCAN_W];
                    scan_err   <= 1'b0;
                end else if (tmo_hit) begin
                    scan_rdata <= '0;
                    scan_err   <= 1'b1;
                end
            end
        end
    end

`ifdef SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == SRAM_WAIT) && !sram_ready && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != SRAM_WAIT) tmo_cnt <= '0;
        else                           tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    // Never times out; TIMEOUT is non-negative so this is constant false.
    assign tmo_hit = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_scan_mem_reg_bridge.sv
// tb/tb_scan_mem_reg_bridge.sv - directed self-checking bench for scan_mem_reg_bridge
module tb_scan_mem_reg_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         scan_ren, scan_wen;
    logic [10:0]  scan_addr;
    logic [31:0]  scan_wdata;
    logic [31:0]  scan_rdata;
    logic         scan_ready, scan_err, scan_busy;
    logic         sram_ren, sram_wen;
    logic [7:0]   sram_addr;
    logic [127:0] sram_wdata, sram_bweb, sram_rdata;
    logic         sram_ready;
    logic [127:0] reg_q;
    logic [31:0]  status_in;

    int checks = 0;
    int errors = 0;

    scan_mem_reg_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .scan_ren   (scan_ren),
        .scan_wen   (scan_wen),
        .scan_addr  (scan_addr),
        .scan_wdata (scan_wdata),
        .scan_rdata (scan_rdata),
        .scan_ready (scan_ready),
        .scan_err   (scan_err),
        .scan_busy  (scan_busy),
        .sram_ren   (sram_ren),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_bweb  (sram_bweb),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready),
        .reg_q      (reg_q),
        .status_in  (status_in)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] exp_rdata, input logic exp_err);
        chk({tag, "_ready"}, 128'(scan_ready), 128'd1);
        chk({tag, "_err"},   128'(scan_err),   128'(exp_err));
        chk({tag, "_rdata"}, 128'(scan_rdata), 128'(exp_rdata));
    endtask

    task automatic issue(input logic ren, input logic wen, input logic [10:0] addr, input logic [31:0] wdata);
        scan_ren   = ren;
        scan_wen   = wen;
        scan_addr  = addr;
        scan_wdata = wdata;
        step();
        scan_ren   = 1'b0;
        scan_wen   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        scan_ren = 1'b0; scan_wen = 1'b0; scan_addr = '0; scan_wdata = '0;
        sram_rdata = '0; sram_ready = 1'b0; status_in = '0;
        step();
        step();
        chk("rst_ready", 128'(scan_ready), 128'd0);
        chk("rst_busy",  128'(scan_busy),  128'd0);
        chk("rst_err",   128'(scan_err),   128'd0);
        chk("rst_rdata", 128'(scan_rdata), 128'd0);
        chk("rst_regq",  reg_q,            128'd0);
        chk("rst_sren",  128'({sram_ren, sram_wen}), 128'd0);
        chk("rst_saddr", 128'(sram_addr),  128'd0);
        chk("rst_swd",   sram_wdata,       128'd0);
        chk("rst_bweb",  sram_bweb,        {128{1'b1}});
        rst = 1'b0;
        step();

        // register write then read-back
        issue(1'b0, 1'b1, 11'h401, 32'h000000A5);
        chk_resp("rw1", 32'h0, 1'b0);
        chk("rw1_regq", reg_q, {64'h0, 32'h000000A5, 32'h0});
        chk("rw1_busy", 128'(scan_busy), 128'd1);
        step();
        chk("rw1_idle_ready", 128'(scan_ready), 128'd0);
        chk("rw1_idle_busy",  128'(scan_busy),  128'd0);
        issue(1'b1, 1'b0, 11'h401, 32'h0);
        chk_resp("rr1", 32'h000000A5, 1'b0);
        step();
        chk("rr1_hold_rdata", 128'(scan_rdata), 128'h000000A5);
        chk("rr1_hold_ready", 128'(scan_ready), 128'd0);

        // SRAM write, lane 2 of word 1
        issue(1'b0, 1'b1, 11'h006, 32'hDEADBEEF);
        chk("sw_wen",   128'(sram_wen),  128'd1);
        chk("sw_ren",   128'(sram_ren),  128'd0);
        chk("sw_addr",  128'(sram_addr), 128'd1);
        chk("sw_bweb",  sram_bweb,  {{32{1'b1}}, 32'h0, {64{1'b1}}});
        chk("sw_wdata", sram_wdata, {32'h0, 32'hDEADBEEF, 64'h0});
        chk("sw_ready0", 128'(scan_ready), 128'd0);
        step();
        chk("sw_wen_off",  128'(sram_wen), 128'd0);
        chk("sw_bweb_off", sram_bweb, {128{1'b1}});
        sram_ready = 1'b1;
        step();
        sram_ready = 1'b0;
        chk_resp("sw", 32'h0, 1'b0);
        step();

        // SRAM read lane 3 of word 0, ready 3 cycles after strobe, stray ready during strobe
        sram_rdata = {32'h12345678, 32'h11111111, 32'h22222222, 32'h33333333};
        issue(1'b1, 1'b0, 11'h003, 32'h0);
        chk("sr_ren",  128'(sram_ren),  128'd1);
        chk("sr_addr", 128'(sram_addr), 128'd0);
        sram_ready = 1'b1;
        step();
        sram_ready = 1'b0;
        chk("sr_w1_ready", 128'(scan_ready), 128'd0);
        chk("sr_w1_ren",   128'(sram_ren),   128'd0);
        scan_wen = 1'b1; scan_addr = 11'h400; scan_wdata = 32'h55;
        step();
        scan_wen = 1'b0;
        chk("sr_w2_ready", 128'(scan_ready), 128'd0);
        chk("sr_w2_busy",  128'(scan_busy),  128'd1);
        sram_ready = 1'b1;
        step();
        sram_ready = 1'b0;
        chk_resp("sr", 32'h12345678, 1'b0);
        chk("busy_ignored_regq", reg_q, {64'h0, 32'h000000A5, 32'h0});
        step();
        chk("sr_after_ready", 128'(scan_ready), 128'd0);

        // status read, status write, out of range
        status_in = 32'h1;
        issue(1'b1, 1'b0, 11'h404, 32'h0);
        status_in = 32'h7;
        chk_resp("st_rd", 32'h1, 1'b0);
        step();
        issue(1'b0, 1'b1, 11'h404, 32'hFFFFFFFF);
        chk_resp("st_wr", 32'h0, 1'b1);
        chk("st_wr_regq", reg_q, {64'h0, 32'h000000A5, 32'h0});
        step();
        issue(1'b1, 1'b0, 11'h407, 32'h0);
        chk_resp("oor_rd", 32'h0, 1'b1);
        step();

        // ren and wen together
        issue(1'b1, 1'b1, 11'h400, 32'h77);
        chk_resp("both", 32'h0, 1'b1);
        chk("both_regq", reg_q, {64'h0, 32'h000000A5, 32'h0});
        step();

        // top register index
        issue(1'b0, 1'b1, 11'h403, 32'hCAFEF00D);
        chk_resp("rw3", 32'h0, 1'b0);
        step();
        issue(1'b1, 1'b0, 11'h403, 32'h0);
        chk_resp("rr3", 32'hCAFEF00D, 1'b0);
        step();

        // SRAM wait with no ready
        issue(1'b1, 1'b0, 11'h000, 32'h0);
        step();
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("tmo_wait%0d", i), 128'({scan_busy, scan_ready}), 128'b10);
            step();
        end
`ifdef SCAN_TIMEOUT_EN
        chk_resp("tmo", 32'h0, 1'b1);
        step();
        chk("tmo_idle", 128'(scan_busy), 128'd0);
`else
        for (int i = 0; i < 20; i++) step();
        chk("notmo_busy",  128'(scan_busy),  128'd1);
        chk("notmo_ready", 128'(scan_ready), 128'd0);
        sram_ready = 1'b1;
        step();
        sram_ready = 1'b0;
        chk_resp("notmo", 32'h33333333, 1'b0);
        step();
`endif

        // reset during SRAM_WAIT
        issue(1'b1, 1'b0, 11'h010, 32'h0);
        step();
        chk("rw_wait_addr", 128'(sram_addr), 128'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_ready", 128'(scan_ready), 128'd0);
        chk("rw_busy",  128'(scan_busy),  128'd0);
        chk("rw_err",   128'(scan_err),   128'd0);
        chk("rw_rdata", 128'(scan_rdata), 128'd0);
        chk("rw_regq",  reg_q,            128'd0);
        chk("rw_saddr", 128'(sram_addr),  128'd0);
        chk("rw_bweb",  sram_bweb,        {128{1'b1}});
        sram_ready = 1'b1;
        step();
        sram_ready = 1'b0;
        chk("rw_idle_ready1", 128'(scan_ready), 128'd0);
        step();
        chk("rw_idle_ready2", 128'(scan_ready), 128'd0);
        chk("rw_idle_busy",   128'(scan_busy),  128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_mem_reg_bridge.md
SCAN_MEM_REG_BRIDGE -- requirements
Module: scan_mem_reg_bridge

Interface
REQ-001 SHALL have parameter SCAN_W, default 32: scan data width.
REQ-002 SHALL have parameter SRAM_W, default 128: SRAM word width, integer multiple of SCAN_W; LANES = SRAM_W/SCAN_W, a power of 2.
REQ-003 SHALL have parameter ADDR_W, default 11: scan address width; SA_W = ADDR_W-1-log2(LANES), default 8.
REQ-004 SHALL have parameter NUM_REGS, default 4: number of read/write control registers; RI_W = clog2(NUM_REGS+1).
REQ-005 SHALL have parameter TIMEOUT, default 15: maximum SRAM wait cycles.
REQ-006 SHALL have ports, in this order:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- scan_ren, scan_wen  in  1 each  scan read/write request.
- scan_addr  in  ADDR_W  scan address.
- scan_wdata  in  SCAN_W  write data.
- scan_rdata  out  SCAN_W  read data, valid with scan_ready.
- scan_ready  out  1  one-cycle response pulse.
- scan_err  out  1  error flag, valid with scan_ready.
- scan_busy  out  1  transaction in flight.
- sram_ren, sram_wen  out  1 each  SRAM read/write strobes.
- sram_addr  out  SA_W  SRAM word index.
- sram_wdata  out  SRAM_W  SRAM write data.
- sram_bweb  out  SRAM_W  active-low bit write enable.
- sram_rdata  in  SRAM_W  SRAM read data.
- sram_ready  in  1  SRAM completion.
- reg_q  out  NUM_REGS*SCAN_W  flattened control registers; reg k at [k*SCAN_W +: SCAN_W].
- status_in  in  SCAN_W  read-only status word.

Function
REQ-007 SHALL decode scan_addr[ADDR_W-1]: 0 = SRAM; 1 = register space, index = scan_addr[RI_W-1:0].
REQ-008 SHALL decode SRAM lane = scan_addr[log2(LANES)-1:0] and word = scan_addr[ADDR_W-2 : log2(LANES)].
REQ-009 SHALL implement FSM IDLE -> SRAM_REQ -> SRAM_WAIT -> RESP -> IDLE; register accesses take IDLE -> RESP.
REQ-010 SHALL accept a request only in IDLE; it SHALL capture addr/wdata/op on accept and ignore requests in any other state.
REQ-011 SHALL assert scan_busy in every state except IDLE.
REQ-012 SHALL treat scan_ren and scan_wen asserted together as illegal: no side effects; RESP with scan_err=1, rdata 0.
REQ-013 SHALL, on a register write to index < NUM_REGS, update reg_q on the accept edge; RESP on the next cycle.
REQ-014 SHALL return reg k on register reads, and status_in (sampled at accept) for index NUM_REGS.
REQ-015 SHALL respond to writes to index NUM_REGS, and to any access with index > NUM_REGS, with scan_err=1 and no state change.
REQ-016 SHALL, in SRAM_REQ, drive sram_ren or sram_wen high for exactly one cycle, together with the captured word index.
REQ-017 SHALL, on SRAM writes, place wdata in the selected lane with zeros elsewhere; sram_bweb SHALL be 0 on that lane and 1 elsewhere.
REQ-018 SHALL hold sram_bweb all-ones whenever sram_wen is low.
REQ-019 SHALL remain in SRAM_WAIT until sram_ready, then capture the selected lane of sram_rdata (writes: rdata 0) and enter RESP.
REQ-020 SHALL recognise sram_ready only in SRAM_WAIT; sram_ready in any other state SHALL be ignored.
REQ-021 SHALL pulse scan_ready for exactly one cycle, in RESP; scan_rdata and scan_err SHALL be registered and held until the next RESP.
REQ-022 SHALL give latencies from accept edge to scan_ready: registers 1 cycle; SRAM 2 cycles + wait cycles.

Reset
REQ-023 SHALL, while rst is high at a clock edge, set: state IDLE; all reg_q, scan_rdata, scan_ready, scan_err, scan_busy, sram_ren, sram_wen, sram_addr and sram_wdata to 0; sram_bweb all-ones; timeout counter 0.
REQ-024 SHALL abandon an in-flight transaction on reset without issuing scan_ready.

Configuration
REQ-025 SHALL, with SCAN_TIMEOUT_EN defined, count cycles in SRAM_WAIT; on reaching TIMEOUT without sram_ready, enter RESP with scan_err=1, rdata 0.
REQ-026 SHALL, without SCAN_TIMEOUT_EN, wait indefinitely in SRAM_WAIT and contain no timeout counter.

Verification
REQ-027 Reg write addr 0x401, wdata 0xA5 -> reg_q[63:32]=0xA5 after accept; scan_ready at +1, err 0; read-back returns 0xA5.
REQ-028 SRAM write addr 0x006, wdata 0xDEADBEEF -> sram_wen pulse, sram_addr 1, bweb[95:64]=0, other bits 1, wdata[95:64]=0xDEADBEEF.
REQ-029 SRAM read addr 0x003, sram_ready 3 cycles after strobe, rdata[127:96]=0x12345678 -> scan_rdata 0x12345678, err 0.
REQ-030 Read addr 0x404 with status_in=1 -> rdata 1; write 0x404 -> err 1, regs unchanged; read 0x407 -> err 1.
REQ-031 ren+wen together; second request while busy; rst in SRAM_WAIT -> err 1; request ignored; no scan_ready, all outputs at reset values.
REQ-032 SCAN_TIMEOUT_EN defined, sram_ready held low -> scan_err=1 after exactly 15 wait cycles; undefined -> busy persists.
